// File: rtl/argmax_node.sv
// argmax_node: compare-select of two (value, index) pairs; b wins only when strictly greater.
module argmax_node #(
  parameter int N = 8,
  parameter int I = 4
) (
  input  logic [N-1:0] a_val,
  input  logic [I-1:0] a_idx,
  input  logic [N-1:0] b_val,
  input  logic [I-1:0] b_idx,
  output logic [N-1:0] o_val,
  output logic [I-1:0] o_idx
);
  logic take_b;
  assign take_b = b_val > a_val;
  assign o_val  = take_b ? b_val : a_val;
  assign o_idx  = take_b ? b_idx : a_idx;
endmodule

// File: rtl/argmax.sv
// argmax: registered index/value of the largest of K unsigned N-bit scores, lowest index on ties.
module argmax #(
  parameter int N = 8,
  parameter int K = 4,
  parameter int I = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N*K-1:0] inx,
  input  logic         in_valid,
  output logic [I-1:0] outimax,
  output logic [N-1:0] outmax,
  output logic         out_valid
);
  localparam int IDXW = $clog2(K);
  localparam int L = IDXW;
  if (I < IDXW) begin : g_chk
    $error("argmax: I too narrow for K");
  end
  function automatic int cnt(input int l);
    int c = K;
    for (int t = 0; t < l; t++) c = (c + 1) / 2;
    return c;
  endfunction
  logic [N-1:0] val [L+1][K];
  logic [I-1:0] idx [L+1][K];
  genvar l, j;
  for (j = 0; j < K; j++) begin : g_leaf
    assign val[0][j] = inx[j*N +: N];
    assign idx[0][j] = I'(j);
  end
  // level l+1 slot j reduces slots 2j and 2j+1 of level l; an odd tail slot passes through
  for (l = 0; l < L; l++) begin : g_lvl
    for (j = 0; j < K; j++) begin : g_slot
      if (j < cnt(l) / 2) begin : g_node
        argmax_node #(.N(N), .I(I)) u_node (
          .a_val(val[l][2*j]),
          .a_idx(idx[l][2*j]),
          .b_val(val[l][2*j+1]),
          .b_idx(idx[l][2*j+1]),
          .o_val(val[l+1][j]),
          .o_idx(idx[l+1][j])
        );
      end else if (j == cnt(l) / 2 && cnt(l) % 2 == 1) begin : g_pass
        assign val[l+1][j] = val[l][2*j];
        assign idx[l+1][j] = idx[l][2*j];
      end else begin : g_zero
        assign val[l+1][j] = '0;
        assign idx[l+1][j] = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outimax   <= '0;
      outmax    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        outimax <= idx[L][0];
        outmax  <= val[L][0];
      end
    end
  end
endmodule

// File: tb/tb_argmax.sv
// tb_argmax: scoreboard bench for argmax at K=4/N=8/I=4 and K=5/N=4/I=3.
module tb_argmax;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inx = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  outimax;
  logic [7:0]  outmax;
  logic        out_valid;
  logic [19:0] inx5 = '0;
  logic        in_valid5 = 1'b0;
  logic [2:0]  outimax5;
  logic [3:0]  outmax5;
  logic        out_valid5;
  int n_chk = 0;
  int n_fail = 0;
  logic [11:0] q4 [$];
  logic [6:0]  q5 [$];
  logic [11:0] held4 = '0;
  logic [6:0]  held5 = '0;

  always #5 clk = ~clk;

  argmax #(.N(8), .K(4), .I(4)) dut (
    .clk(clk), .rst_n(rst_n), .inx(inx), .in_valid(in_valid),
    .outimax(outimax), .outmax(outmax), .out_valid(out_valid)
  );
  argmax #(.N(4), .K(5), .I(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .inx(inx5), .in_valid(in_valid5),
    .outimax(outimax5), .outmax(outmax5), .out_valid(out_valid5)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] ref4(input logic [31:0] x);
    logic [7:0] b = x[7:0];
    logic [3:0] bi = 0;
    for (int k = 1; k < 4; k++) begin
      logic [7:0] s = x[k*8 +: 8];
      if (s > b) begin b = s; bi = 4'(k); end
    end
    return {bi, b};
  endfunction

  function automatic logic [6:0] ref5(input logic [19:0] x);
    logic [3:0] b = x[3:0];
    logic [2:0] bi = 0;
    for (int k = 1; k < 5; k++) begin
      logic [3:0] s = x[k*4 +: 4];
      if (s > b) begin b = s; bi = 3'(k); end
    end
    return {bi, b};
  endfunction

  task automatic tick(input logic [31:0] x, input logic v, input logic [19:0] y, input logic w);
    logic [11:0] e4;
    logic [6:0]  e5;
    inx = v ? x : 'x;
    in_valid = v;
    inx5 = w ? y : 'x;
    in_valid5 = w;
    if (v) q4.push_back(ref4(x));
    if (w) q5.push_back(ref5(y));
    @(posedge clk);
    #1;
    check("valid4", 32'(out_valid), 32'(v));
    check("valid5", 32'(out_valid5), 32'(w));
    if (v) begin
      if (q4.size() == 0) begin check("sb4_empty", 1, 0); e4 = '0; end
      else e4 = q4.pop_front();
      held4 = e4;
    end
    check(v ? "idx4" : "hold_idx4", 32'(outimax), 32'(held4[11:8]));
    check(v ? "max4" : "hold_max4", 32'(outmax), 32'(held4[7:0]));
    if (w) begin
      if (q5.size() == 0) begin check("sb5_empty", 1, 0); e5 = '0; end
      else e5 = q5.pop_front();
      held5 = e5;
    end
    check(w ? "idx5" : "hold_idx5", 32'(outimax5), 32'(held5[6:4]));
    check(w ? "max5" : "hold_max5", 32'(outmax5), 32'(held5[3:0]));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_idx", 32'(outimax), 0);
    check("rst_max", 32'(outmax), 0);
    check("rst_valid5", 32'(out_valid5), 0);
    rst_n = 1'b1;
    tick(32'h12e9f3d3, 1, 20'h3a9a1, 1);
    check("ref_idx", 32'(outimax), 1);
    check("ref_max", 32'(outmax), 32'hf3);
    check("ref5_idx", 32'(outimax5), 1);
    check("ref5_max", 32'(outmax5), 32'ha);
    tick(32'h80808080, 1, 20'h55555, 1);
    check("tie_all", 32'(outimax), 0);
    tick(32'h7f7f0000, 1, 20'hf000f, 1);
    check("tie_hi", 32'(outimax), 2);
    tick(32'hff000000, 1, 20'hf0000, 1);
    check("top_idx", 32'(outimax), 3);
    check("top5_idx", 32'(outimax5), 4);
    tick(32'h00000000, 1, 20'h00000, 1);
    tick(32'h000000ff, 1, 20'h0000f, 1);
    tick(32'h000000ff, 1, 20'h000f0, 1);
    tick(32'h0000ff00, 1, 20'h00f00, 1);
    tick(32'h00ff0000, 1, 20'h0f000, 1);
    check("b2b_idx", 32'(outimax), 2);
    tick('0, 0, '0, 0);
    check("idle_hold", 32'(outimax), 2);
    tick(32'h0000f300, 1, 20'h00a00, 1);
    // reset between edges with a vector pending: outputs clear at once, pending result is dropped
    inx = 32'h00f30000;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_idx", 32'(outimax), 0);
    check("arst_max", 32'(outmax), 0);
    check("arst_valid5", 32'(out_valid5), 0);
    @(posedge clk);
    #1;
    check("arst_hold", 32'(out_valid), 0);
    rst_n = 1'b1;
    held4 = '0;
    held5 = '0;
    tick('0, 0, '0, 0);
    tick(32'h00f30000, 1, 20'h3a9a1, 1);
    check("post_rst_idx", 32'(outimax), 2);
    for (int r = 0; r < 200; r++)
      tick($urandom, ($urandom_range(0, 3) != 0), 20'($urandom), ($urandom_range(0, 3) != 0));
    for (int r = 0; r < 50; r++) begin
      logic [7:0] s = 8'($urandom);
      logic [3:0] t = 4'($urandom);
      tick({s, 8'($urandom), s, s}, 1, {t, t, t, t, t}, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
